// File: rtl/cordiccart2pol_vector_core_pkg.sv
// Shared types and constants for the iterative CORDIC vectoring core.
// Angles are signed Q3.29 radians; the gain constant is unsigned Q0.30.
package cordiccart2pol_vector_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ATAN_W = 32;
    localparam int ATAN_N = 28;
    localparam int ITER_W = 5;

    localparam logic signed [ATAN_W-1:0] PI_HALF     = 32'sd843314857;
    localparam logic signed [ATAN_W-1:0] PI          = 32'sd1686629713;
    localparam logic        [ATAN_W-1:0] K_GAIN_Q030 = 32'd652032875;

    // atan(2^-i) in Q3.29, i = 0..27
    localparam logic signed [ATAN_W-1:0] ATAN_TABLE [0:ATAN_N-1] = '{
        32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
        32'sd33510843,  32'sd16771758,  32'sd8387926,   32'sd4194219,
        32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
        32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
        32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
        32'sd512,       32'sd256,       32'sd128,       32'sd64,
        32'sd32,        32'sd16,        32'sd8,         32'sd4
    };

    function automatic logic signed [ATAN_W-1:0] atan_lookup(input logic [ITER_W-1:0] idx);
        if (idx < ITER_W'(ATAN_N)) begin
            return ATAN_TABLE[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/cordiccart2pol_vector_core_if.sv
// Sample-in / result-out handshake bundle of the CORDIC vectoring core.
interface cordiccart2pol_vector_core_if #(
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic        [DATA_W-1:0] r_raw;
    logic signed [DATA_W-1:0] theta;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, r_raw, theta
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, r_raw, theta
    );
endinterface

// File: rtl/cordiccart2pol_vector_core_atan_rom.sv
// Combinational arctangent table: iteration index -> atan(2^-i) in Q3.29.
module cordiccart2pol_vector_core_atan_rom
    import cordiccart2pol_vector_core_pkg::*;
(
    input  logic        [ITER_W-1:0] i_idx,
    output logic signed [ATAN_W-1:0] o_atan
);

    assign o_atan = atan_lookup(i_idx);

endmodule

// File: rtl/cordiccart2pol_vector_core.sv
// Iterative CORDIC vectoring: (x, y) -> unscaled magnitude and angle,
// one micro-rotation per clock, one sample in flight at a time.
module cordiccart2pol_vector_core
    import cordiccart2pol_vector_core_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_ITER = 16,
    parameter int GUARD_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    cordiccart2pol_vector_core_if.slave  bus
);

    localparam int IW = DATA_W + GUARD_W;
    localparam logic signed [IW-1:0]     R_MAX     = {{(GUARD_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic        [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_in_ready;
    logic                     w_out_valid;

    logic signed [IW-1:0]     r_x;
    logic signed [IW-1:0]     r_y;
    logic signed [DATA_W-1:0] r_z;
    logic        [ITER_W-1:0] r_iter;
    logic                     r_zero;
    logic        [DATA_W-1:0] r_r_raw;
    logic signed [DATA_W-1:0] r_theta;

    logic signed [IW-1:0]     w_x_ext;
    logic signed [IW-1:0]     w_y_ext;
    logic signed [IW-1:0]     w_x_pre;
    logic signed [IW-1:0]     w_y_pre;
    logic signed [DATA_W-1:0] w_z_pre;
    logic signed [IW-1:0]     w_x_sh;
    logic signed [IW-1:0]     w_y_sh;
    logic signed [IW-1:0]     w_x_rot;
    logic signed [IW-1:0]     w_y_rot;
    logic signed [DATA_W-1:0] w_z_rot;
    logic signed [ATAN_W-1:0] w_atan;
    logic signed [DATA_W-1:0] w_atan_ext;
    logic        [DATA_W-1:0] w_r_sat;
    logic                     w_is_zero;

    cordiccart2pol_vector_core_atan_rom u_atan_rom (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    assign w_atan_ext = DATA_W'(w_atan);
    assign w_x_ext    = {{GUARD_W{bus.x_in[DATA_W-1]}}, bus.x_in};
    assign w_y_ext    = {{GUARD_W{bus.y_in[DATA_W-1]}}, bus.y_in};
    assign w_is_zero  = (bus.x_in == '0) && (bus.y_in == '0);

    // Fold the left half-plane into x >= 0 so the rotations only need to cover +-pi/2
    always_comb begin
        w_x_pre = w_x_ext;
        w_y_pre = w_y_ext;
        w_z_pre = '0;
        if (w_x_ext[IW-1]) begin
            if (!w_y_ext[IW-1]) begin
                w_x_pre = w_y_ext;
                w_y_pre = -w_x_ext;
                w_z_pre = DATA_W'(PI_HALF);
            end else begin
                w_x_pre = -w_y_ext;
                w_y_pre = w_x_ext;
                w_z_pre = -DATA_W'(PI_HALF);
            end
        end
    end

    assign w_x_sh = r_x >>> r_iter;
    assign w_y_sh = r_y >>> r_iter;

    always_comb begin
        w_x_rot = r_x + w_y_sh;
        w_y_rot = r_y - w_x_sh;
        w_z_rot = r_z + w_atan_ext;
        if (r_y[IW-1]) begin
            w_x_rot = r_x - w_y_sh;
            w_y_rot = r_y + w_x_sh;
            w_z_rot = r_z - w_atan_ext;
        end
    end

    // Gain can push the magnitude past the output range; the guard bits hold the overflow
    assign w_r_sat = (w_x_rot > R_MAX) ? R_MAX[DATA_W-1:0] : w_x_rot[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = ITER;
                end
            end
            ITER: begin
                if (r_iter == LAST_ITER) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_zero  <= 1'b0;
            r_r_raw <= '0;
            r_theta <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x    <= w_x_pre;
                        r_y    <= w_y_pre;
                        r_z    <= w_z_pre;
                        r_iter <= '0;
                        r_zero <= w_is_zero;
                    end
                end
                ITER: begin
                    r_x    <= w_x_rot;
                    r_y    <= w_y_rot;
                    r_z    <= w_z_rot;
                    r_iter <= r_iter + ITER_W'(1);
                    // Zero input has no defined angle; report an exact 0/0 instead of the atan sum
                    if (r_iter == LAST_ITER) begin
                        r_r_raw <= r_zero ? '0 : w_r_sat;
                        r_theta <= r_zero ? '0 : w_z_rot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.r_raw     = r_r_raw;
    assign bus.theta     = r_theta;

endmodule

// File: tb/tb_cordiccart2pol_vector_core.sv
// Self-checking bench for the CORDIC vectoring core: scoreboard of expected
// magnitude/angle pushed at the input handshake, popped at the output handshake.
module tb_cordiccart2pol_vector_core;

    localparam int  NUM_ITER = 16;
    localparam longint TOL   = 32768;
    localparam longint RMAX  = 64'd2147483647;

    typedef struct {
        longint r;
        longint t;
        longint tol_r;
        longint tol_t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cordiccart2pol_vector_core_if #(.DATA_W(32)) bus ();

    cordiccart2pol_vector_core #(
        .DATA_W   (32),
        .NUM_ITER (NUM_ITER),
        .GUARD_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic bit near(input int a, input longint e, input longint tol);
        longint d;
        d = longint'(a) - e;
        return (d <= tol) && (d >= -tol);
    endfunction

    // Floating-point reference: |(x,y)| times the CORDIC gain, atan2 in Q3.29
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        real  kg;
        real  p;
        real  mag;
        kg = 1.0;
        p  = 1.0;
        for (int i = 0; i < NUM_ITER; i++) begin
            kg = kg * $sqrt(1.0 + p);
            p  = p / 4.0;
        end
        if (x == 0 && y == 0) begin
            e = '{r: 0, t: 0, tol_r: 0, tol_t: 0};
            return e;
        end
        mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * kg;
        if (mag > 2147483647.0 + 65536.0) begin
            e.r = RMAX;
            e.tol_r = 0;
        end else begin
            e.r = (mag > 2147483647.0) ? RMAX : longint'(mag);
            e.tol_r = TOL;
        end
        e.t = longint'($atan2(real'(y), real'(x)) * 536870912.0);
        e.tol_t = TOL;
        return e;
    endfunction

    task automatic send(input int x, input int y, input exp_t e, input string name);
        int cnt;
        cnt = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.y_in     = y;
        while (!bus.in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        tests++;
        if (!bus.in_ready) begin
            failed++;
            $display("FAIL %s accept_timeout in_ready=%0b required=1", name, bus.in_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(output int r, output int t, output bit ok);
        int cnt;
        cnt = 0;
        while (!bus.out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        ok = bus.out_valid;
        r  = bus.r_raw;
        t  = bus.theta;
        if (ok) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e = '{r: -1, t: 0, tol_r: 0, tol_t: 0};
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.in_ready !== 1'b1)  begin failed++; $display("FAIL reset_in_ready actual=%0b required=1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid actual=%0b required=0", bus.out_valid); end
        tests++; if (bus.r_raw !== 32'd0)    begin failed++; $display("FAIL reset_r_raw actual=%0d required=0", bus.r_raw); end
        tests++; if (bus.theta !== 32'd0)    begin failed++; $display("FAIL reset_theta actual=%0d required=0", bus.theta); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failed++; $display("FAIL post_reset_idle in_ready=%0b out_valid=%0b required=1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_latency();
        int   lat;
        int   r;
        int   t;
        bit   ok;
        exp_t e;
        send(536870912, 0, '{r: 884097680, t: 0, tol_r: TOL, tol_t: TOL}, "latency");
        // lat is the cycle index relative to the handshake cycle T
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++; if (lat != NUM_ITER + 1) begin failed++; $display("FAIL latency actual=%0d required=%0d", lat, NUM_ITER + 1); end
        get_result(r, t, ok);
        e = pop_exp();
        tests++; if (!ok) begin failed++; $display("FAIL latency_result timeout out_valid=0 required=1"); end
        tests++; if (!near(r, e.r, e.tol_r)) begin failed++; $display("FAIL latency_r_raw actual=%0d required=%0d tol=%0d", r, e.r, e.tol_r); end
        tests++; if (!near(t, e.t, e.tol_t)) begin failed++; $display("FAIL latency_theta actual=%0d required=%0d tol=%0d", t, e.t, e.tol_t); end
    endtask

    task automatic test_axes();
        int    xs[7];
        int    ys[7];
        exp_t  es[7];
        string ns[7];
        int    r;
        int    t;
        bit    ok;
        exp_t  e;
        xs[0] = 0;            ys[0] = 536870912;    es[0] = '{r: 884097680, t: 843314857, tol_r: TOL, tol_t: TOL};    ns[0] = "pos_y";
        xs[1] = -536870912;   ys[1] = 0;            es[1] = '{r: 884097680, t: 1686629713, tol_r: TOL, tol_t: TOL};   ns[1] = "neg_x_plus_pi";
        xs[2] = -536870912;   ys[2] = -1;           es[2] = '{r: 884097680, t: -1686629713, tol_r: TOL, tol_t: TOL};  ns[2] = "neg_x_minus_pi";
        xs[3] = 0;            ys[3] = 0;            es[3] = '{r: 0, t: 0, tol_r: 0, tol_t: 0};                        ns[3] = "zero";
        xs[4] = 32'h7FFFFFFF; ys[4] = 32'h7FFFFFFF; es[4] = '{r: RMAX, t: 421657428, tol_r: 0, tol_t: TOL};           ns[4] = "saturate";
        xs[5] = 32'h80000000; ys[5] = 0;            es[5] = '{r: RMAX, t: 1686629713, tol_r: 0, tol_t: TOL};          ns[5] = "x_most_neg";
        xs[6] = 0;            ys[6] = -536870912;   es[6] = '{r: 884097680, t: -843314857, tol_r: TOL, tol_t: TOL};   ns[6] = "neg_y";
        for (int k = 0; k < 7; k++) begin
            send(xs[k], ys[k], es[k], ns[k]);
            get_result(r, t, ok);
            e = pop_exp();
            tests++; if (!ok) begin failed++; $display("FAIL %s timeout out_valid=0 required=1", ns[k]); end
            tests++; if (!near(r, e.r, e.tol_r)) begin failed++; $display("FAIL %s r_raw actual=%0d required=%0d tol=%0d", ns[k], r, e.r, e.tol_r); end
            tests++; if (!near(t, e.t, e.tol_t)) begin failed++; $display("FAIL %s theta actual=%0d required=%0d tol=%0d", ns[k], t, e.t, e.tol_t); end
            $display("[TB] %s x=%0d y=%0d r_raw=%0d theta=%0d", ns[k], xs[k], ys[k], r, t);
        end
    endtask

    task automatic test_random();
        int   x;
        int   y;
        int   r;
        int   t;
        bit   ok;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            x = $signed($urandom()) >>> 1;
            y = $signed($urandom()) >>> 1;
            send(x, y, model(x, y), "random");
            get_result(r, t, ok);
            e = pop_exp();
            tests++; if (!ok) begin failed++; $display("FAIL random%0d timeout out_valid=0 required=1", k); end
            tests++; if (!near(r, e.r, e.tol_r)) begin failed++; $display("FAIL random%0d r_raw actual=%0d required=%0d tol=%0d", k, r, e.r, e.tol_r); end
            tests++; if (!near(t, e.t, e.tol_t)) begin failed++; $display("FAIL random%0d theta actual=%0d required=%0d tol=%0d", k, t, e.t, e.tol_t); end
            $display("[TB] random%0d x=%0d y=%0d r_raw=%0d theta=%0d", k, x, y, r, t);
        end
    endtask

    task automatic test_backpressure();
        exp_t e1;
        exp_t e2;
        exp_t e;
        int   cnt;
        int   r;
        int   t;
        bit   ok;
        e1 = model(300000000, -200000000);
        e2 = model(-100000000, 400000000);
        send(300000000, -200000000, e1, "bp1");
        cnt = 0;
        while (!bus.out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        bus.in_valid = 1'b1;
        bus.x_in     = -100000000;
        bus.y_in     = 400000000;
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus.out_valid !== 1'b1) begin failed++; $display("FAIL bp_hold%0d out_valid actual=%0b required=1", k, bus.out_valid); end
            tests++; if (bus.in_ready !== 1'b0)  begin failed++; $display("FAIL bp_hold%0d in_ready actual=%0b required=0", k, bus.in_ready); end
            tests++; if (!near(bus.r_raw, e1.r, e1.tol_r)) begin failed++; $display("FAIL bp_hold%0d r_raw actual=%0d required=%0d", k, bus.r_raw, e1.r); end
            tests++; if (!near(bus.theta, e1.t, e1.tol_t)) begin failed++; $display("FAIL bp_hold%0d theta actual=%0d required=%0d", k, $signed(bus.theta), e1.t); end
            @(negedge clk);
        end
        e = pop_exp();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        $display("[TB] bp1 released expected r_raw=%0d theta=%0d", e.r, e.t);
        tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failed++; $display("FAIL bp_release in_ready=%0b out_valid=%0b required=1/0", bus.in_ready, bus.out_valid);
        end
        sb.push_back(e2);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL bp_accept in_ready actual=%0b required=0", bus.in_ready); end
        get_result(r, t, ok);
        e = pop_exp();
        tests++; if (!ok) begin failed++; $display("FAIL bp2 timeout out_valid=0 required=1"); end
        tests++; if (!near(r, e.r, e.tol_r)) begin failed++; $display("FAIL bp2 r_raw actual=%0d required=%0d tol=%0d", r, e.r, e.tol_r); end
        tests++; if (!near(t, e.t, e.tol_t)) begin failed++; $display("FAIL bp2 theta actual=%0d required=%0d tol=%0d", t, e.t, e.tol_t); end
    endtask

    task automatic test_reset_mid();
        int   r;
        int   t;
        bit   ok;
        exp_t e;
        send(-700000000, -900000000, model(-700000000, -900000000), "aborted");
        // Seven more edges leave the core about to perform iteration 7
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin failed++; $display("FAIL rst_mid out_valid actual=%0b required=0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b1)  begin failed++; $display("FAIL rst_mid in_ready actual=%0b required=1", bus.in_ready); end
        tests++; if (bus.r_raw !== 32'd0 || bus.theta !== 32'd0) begin
            failed++; $display("FAIL rst_mid outputs r_raw=%0d theta=%0d required=0/0", bus.r_raw, bus.theta);
        end
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        @(negedge clk);
        rst = 1'b0;
        send(200000000, 100000000, model(200000000, 100000000), "after_rst");
        get_result(r, t, ok);
        e = pop_exp();
        tests++; if (!ok) begin failed++; $display("FAIL after_rst timeout out_valid=0 required=1"); end
        tests++; if (!near(r, e.r, e.tol_r)) begin failed++; $display("FAIL after_rst r_raw actual=%0d required=%0d tol=%0d", r, e.r, e.tol_r); end
        tests++; if (!near(t, e.t, e.tol_t)) begin failed++; $display("FAIL after_rst theta actual=%0d required=%0d tol=%0d", t, e.t, e.tol_t); end
    endtask

    task automatic test_back_to_back();
        int   xs[3];
        int   ys[3];
        int   cyc;
        int   acc;
        int   got;
        int   last_acc;
        exp_t e;
        xs[0] = 400000000;  ys[0] = 400000000;
        xs[1] = -50000000;  ys[1] = -600000000;
        xs[2] = 123456789;  ys[2] = -987654321;
        cyc = 0; acc = 0; got = 0; last_acc = -1;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.x_in      = xs[0];
        bus.y_in      = ys[0];
        while ((acc < 3 || got < 3) && cyc < 300) begin
            if (bus.out_valid) begin
                e = pop_exp();
                tests++; if (!near(bus.r_raw, e.r, e.tol_r)) begin failed++; $display("FAIL b2b%0d r_raw actual=%0d required=%0d", got, bus.r_raw, e.r); end
                tests++; if (!near(bus.theta, e.t, e.tol_t)) begin failed++; $display("FAIL b2b%0d theta actual=%0d required=%0d", got, $signed(bus.theta), e.t); end
                $display("[TB] b2b%0d r_raw=%0d theta=%0d", got, bus.r_raw, $signed(bus.theta));
                got++;
            end
            if (bus.in_ready && acc < 3) begin
                sb.push_back(model(xs[acc], ys[acc]));
                if (last_acc >= 0) begin
                    tests++; if (cyc - last_acc != NUM_ITER + 2) begin
                        failed++; $display("FAIL b2b_interval actual=%0d required=%0d", cyc - last_acc, NUM_ITER + 2);
                    end
                end
                last_acc = cyc;
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc < 3) begin
                bus.x_in = xs[acc];
                bus.y_in = ys[acc];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        tests++; if (got != 3) begin failed++; $display("FAIL b2b_count actual=%0d required=3", got); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_axes();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
